video_mode_timing_gen: RTL and testbench

Runtime-switchable HDMI video timing generator. It replaces the single compile-time resolution selection with a table of up to four modes, chosen at runtime. A mode change takes effect only at a frame boundary, so it never produces a torn frame. After reset the block holds video blanked for a configurable power-up window, then runs continuous counters and syncs that feed the scaler and the TMDS encoder.

---
 rtl/video_mode_timing_gen.sv | 119 +++++++++++
 tb/tb_video_mode_timing_gen.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/video_mode_timing_gen.sv
// video_mode_timing_gen: runtime-switchable video timing with frame-boundary mode changes
module video_mode_timing_gen #(
    parameter  int NUM_MODES = 2,
    parameter  int HW = 12,
    parameter  int VW = 11,
    localparam int MW = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1,
    parameter  logic [NUM_MODES*HW-1:0] H_TOTAL  = {12'd1650, 12'd858},
    parameter  logic [NUM_MODES*HW-1:0] H_ACTIVE = {12'd1280, 12'd720},
    parameter  logic [NUM_MODES*HW-1:0] H_FP     = {12'd110, 12'd16},
    parameter  logic [NUM_MODES*HW-1:0] H_SYNC   = {12'd40, 12'd62},
    parameter  logic [NUM_MODES*VW-1:0] V_TOTAL  = {11'd750, 11'd525},
    parameter  logic [NUM_MODES*VW-1:0] V_ACTIVE = {11'd720, 11'd480},
    parameter  logic [NUM_MODES*VW-1:0] V_FP     = {11'd5, 11'd9},
    parameter  logic [NUM_MODES*VW-1:0] V_SYNC   = {11'd5, 11'd6},
    parameter  logic [NUM_MODES-1:0]    SYNC_INV = 2'b01,
    parameter  int DEFAULT_MODE   = 0,
    parameter  int POWERUP_CYCLES = 2700000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [MW-1:0] mode_sel,
    input  logic          mode_req,
    output logic          mode_busy,
    output logic          mode_ack,
    output logic          mode_err,
    output logic [MW-1:0] cur_mode,
    output logic [HW-1:0] h_cnt,
    output logic [VW-1:0] v_cnt,
    output logic          de,
    output logic          hsync,
    output logic          vsync,
    output logic          line_start,
    output logic          frame_start,
    output logic          ready
);
    localparam logic [MW:0] NM = (MW+1)'(NUM_MODES);

    typedef enum logic {PWRUP, RUN} state_t;
    state_t state, state_n;

    logic [21:0]   pw_cnt;
    logic [MW-1:0] target, mode_n;
    logic [HW-1:0] h_n, ha, hsa, hse;
    logic [VW-1:0] v_n, va, vsa, vse;
    logic pw_done, h_last, v_last, apply, sel_ok, run;
    logic de_n, hs_n, vs_n, ls_n, fs_n;

    function automatic logic [HW-1:0] hp(input logic [NUM_MODES*HW-1:0] t, input logic [MW-1:0] m);
        return t[int'(m)*HW +: HW];
    endfunction

    function automatic logic [VW-1:0] vp(input logic [NUM_MODES*VW-1:0] t, input logic [MW-1:0] m);
        return t[int'(m)*VW +: VW];
    endfunction

    // state register: power-up blanking, then free-running forever
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= PWRUP;
        else        state <= state_n;

    // next state, next counters and outputs decoded from the mode that will be in effect
    always_comb begin
        pw_done = (state == PWRUP) && (pw_cnt == 22'(POWERUP_CYCLES - 1));
        h_last  = h_cnt == hp(H_TOTAL, cur_mode) - HW'(1);
        v_last  = v_cnt == vp(V_TOTAL, cur_mode) - VW'(1);
        apply   = mode_busy && (pw_done || (state == RUN && h_last && v_last));
        sel_ok  = {1'b0, mode_sel} < NM;
        state_n = (state == RUN || pw_done) ? RUN : PWRUP;
        run     = state_n == RUN;
        mode_n  = apply ? target : cur_mode;
        h_n     = (state == RUN && !h_last) ? h_cnt + HW'(1) : '0;
        v_n     = (state != RUN || (h_last && v_last)) ? '0 : h_last ? v_cnt + VW'(1) : v_cnt;
        ha      = hp(H_ACTIVE, mode_n);
        hsa     = ha + hp(H_FP, mode_n);
        hse     = hsa + hp(H_SYNC, mode_n);
        va      = vp(V_ACTIVE, mode_n);
        vsa     = va + vp(V_FP, mode_n);
        vse     = vsa + vp(V_SYNC, mode_n);
        de_n    = run && h_n < ha && v_n < va;
        hs_n    = (run && h_n >= hsa && h_n < hse) ^ SYNC_INV[mode_n];
        vs_n    = (run && v_n >= vsa && v_n < vse) ^ SYNC_INV[mode_n];
        ls_n    = run && h_n == '0;
        fs_n    = ls_n && v_n == '0;
    end

    // registered counters, syncs and request bookkeeping
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            pw_cnt      <= '0;
            target      <= MW'(DEFAULT_MODE);
            cur_mode    <= MW'(DEFAULT_MODE);
            mode_busy   <= 1'b0;
            mode_ack    <= 1'b0;
            mode_err    <= 1'b0;
            h_cnt       <= '0;
            v_cnt       <= '0;
            de          <= 1'b0;
            hsync       <= SYNC_INV[DEFAULT_MODE];
            vsync       <= SYNC_INV[DEFAULT_MODE];
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            ready       <= 1'b0;
        end else begin
            pw_cnt      <= (state == PWRUP) ? pw_cnt + 22'd1 : pw_cnt;
            target      <= (mode_req && sel_ok) ? mode_sel : target;
            cur_mode    <= mode_n;
            mode_busy   <= (mode_req && sel_ok) || (mode_busy && !apply);
            mode_ack    <= apply;
            mode_err    <= mode_req && !sel_ok;
            h_cnt       <= h_n;
            v_cnt       <= v_n;
            de          <= de_n;
            hsync       <= hs_n;
            vsync       <= vs_n;
            line_start  <= ls_n;
            frame_start <= fs_n;
            ready       <= run;
        end
endmodule

// File: tb/tb_video_mode_timing_gen.sv
// tb_video_mode_timing_gen: directed vector bench with reduced-size timing tables
module tb_video_mode_timing_gen;
    logic        clk = 1'b0, rst_n = 1'b0, mode_req = 1'b0;
    logic [1:0]  mode_sel = 2'd0;
    logic        mode_busy, mode_ack, mode_err, de, hsync, vsync, line_start, frame_start, ready;
    logic [1:0]  cur_mode;
    logic [11:0] h_cnt;
    logic [10:0] v_cnt;

    int n_cmp = 0, n_err = 0, pos = 0, acks = 0, a0 = 0;
    int ht[3] = '{20, 30, 16};
    int vt[3] = '{10, 12, 8};

    typedef struct {int m; int h; int v; bit de; bit hs; bit vs;} vec_t;
    vec_t vecs[$];

    video_mode_timing_gen #(
        .NUM_MODES(3), .HW(12), .VW(11),
        .H_TOTAL ({12'd16, 12'd30, 12'd20}),
        .H_ACTIVE({12'd10, 12'd24, 12'd12}),
        .H_FP    ({12'd1,  12'd3,  12'd2}),
        .H_SYNC  ({12'd2,  12'd2,  12'd3}),
        .V_TOTAL ({11'd8,  11'd12, 11'd10}),
        .V_ACTIVE({11'd5,  11'd8,  11'd6}),
        .V_FP    ({11'd1,  11'd1,  11'd1}),
        .V_SYNC  ({11'd1,  11'd2,  11'd2}),
        .SYNC_INV(3'b101), .DEFAULT_MODE(0), .POWERUP_CYCLES(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .mode_sel(mode_sel), .mode_req(mode_req),
        .mode_busy(mode_busy), .mode_ack(mode_ack), .mode_err(mode_err), .cur_mode(cur_mode),
        .h_cnt(h_cnt), .v_cnt(v_cnt), .de(de), .hsync(hsync), .vsync(vsync),
        .line_start(line_start), .frame_start(frame_start), .ready(ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        pos++;
        if (mode_ack) acks++;
    endtask

    task automatic go(input int t);
        while (pos < t) tick();
    endtask

    task automatic req(input int s);
        mode_sel = 2'(s);
        mode_req = 1'b1;
        tick();
        mode_req = 1'b0;
    endtask

    task automatic end_frame(input int m);
        go(ht[m] * vt[m] - 1);
        tick();
        pos = 0;
    endtask

    task automatic run_vecs(input int m);
        foreach (vecs[i]) if (vecs[i].m == m) begin
            go(vecs[i].v * ht[m] + vecs[i].h);
            chk($sformatf("m%0d h%0d v%0d h_cnt", m, vecs[i].h, vecs[i].v), int'(h_cnt), vecs[i].h);
            chk($sformatf("m%0d h%0d v%0d v_cnt", m, vecs[i].h, vecs[i].v), int'(v_cnt), vecs[i].v);
            chk($sformatf("m%0d h%0d v%0d de", m, vecs[i].h, vecs[i].v), int'(de), int'(vecs[i].de));
            chk($sformatf("m%0d h%0d v%0d hsync", m, vecs[i].h, vecs[i].v), int'(hsync), int'(vecs[i].hs));
            chk($sformatf("m%0d h%0d v%0d vsync", m, vecs[i].h, vecs[i].v), int'(vsync), int'(vecs[i].vs));
            chk($sformatf("m%0d h%0d v%0d line_start", m, vecs[i].h, vecs[i].v), int'(line_start), int'(vecs[i].h == 0));
            chk($sformatf("m%0d h%0d v%0d frame_start", m, vecs[i].h, vecs[i].v), int'(frame_start),
                int'(vecs[i].h == 0 && vecs[i].v == 0));
        end
    endtask

    task automatic powerup();
        for (int i = 1; i < 16; i++) begin
            tick();
            chk($sformatf("pwrup%0d ready", i), int'(ready), 0);
            chk($sformatf("pwrup%0d syncs", i), int'({hsync, vsync, de, line_start, frame_start}), 5'b11000);
        end
        tick();
        chk("pwrup ready", int'(ready), 1);
        chk("pwrup frame_start", int'(frame_start), 1);
        chk("pwrup line_start", int'(line_start), 1);
        chk("pwrup de", int'(de), 1);
        chk("pwrup hv", int'(h_cnt) + int'(v_cnt), 0);
        pos = 0;
    endtask

    initial begin
        // mode 0: 20x10, syncs active-low at h 14..16, v 7..8
        vecs.push_back('{0, 0, 0, 1, 1, 1});   vecs.push_back('{0, 11, 0, 1, 1, 1});
        vecs.push_back('{0, 12, 0, 0, 1, 1});  vecs.push_back('{0, 13, 0, 0, 1, 1});
        vecs.push_back('{0, 14, 0, 0, 0, 1});  vecs.push_back('{0, 16, 0, 0, 0, 1});
        vecs.push_back('{0, 17, 0, 0, 1, 1});  vecs.push_back('{0, 19, 0, 0, 1, 1});
        vecs.push_back('{0, 0, 1, 1, 1, 1});   vecs.push_back('{0, 5, 5, 1, 1, 1});
        vecs.push_back('{0, 5, 6, 0, 1, 1});   vecs.push_back('{0, 0, 7, 0, 1, 0});
        vecs.push_back('{0, 15, 8, 0, 0, 0});  vecs.push_back('{0, 0, 9, 0, 1, 1});
        vecs.push_back('{0, 19, 9, 0, 1, 1});
        // mode 1: 30x12, syncs active-high at h 27..28, v 9..10
        vecs.push_back('{1, 23, 0, 1, 0, 0});  vecs.push_back('{1, 24, 0, 0, 0, 0});
        vecs.push_back('{1, 27, 0, 0, 1, 0});  vecs.push_back('{1, 28, 0, 0, 1, 0});
        vecs.push_back('{1, 29, 0, 0, 0, 0});  vecs.push_back('{1, 0, 1, 1, 0, 0});
        vecs.push_back('{1, 0, 8, 0, 0, 0});   vecs.push_back('{1, 0, 9, 0, 0, 1});
        vecs.push_back('{1, 28, 10, 0, 1, 1}); vecs.push_back('{1, 0, 11, 0, 0, 0});
        vecs.push_back('{1, 29, 11, 0, 0, 0});
        // mode 2: 16x8, syncs active-low at h 11..12, v 6
        vecs.push_back('{2, 9, 0, 1, 1, 1});   vecs.push_back('{2, 10, 0, 0, 1, 1});
        vecs.push_back('{2, 11, 0, 0, 0, 1});  vecs.push_back('{2, 12, 0, 0, 0, 1});
        vecs.push_back('{2, 13, 0, 0, 1, 1});  vecs.push_back('{2, 0, 5, 0, 1, 1});
        vecs.push_back('{2, 0, 6, 0, 1, 0});   vecs.push_back('{2, 12, 6, 0, 0, 0});
        vecs.push_back('{2, 0, 7, 0, 1, 1});

        tick(); tick();
        chk("rst h_cnt", int'(h_cnt), 0);
        chk("rst v_cnt", int'(v_cnt), 0);
        chk("rst de", int'(de), 0);
        chk("rst hsync", int'(hsync), 1);
        chk("rst vsync", int'(vsync), 1);
        chk("rst pulses", int'({line_start, frame_start, ready}), 0);
        chk("rst req flags", int'({mode_busy, mode_ack, mode_err}), 0);
        chk("rst cur_mode", int'(cur_mode), 0);
        rst_n = 1'b1;
        powerup();

        run_vecs(0);
        end_frame(0);
        chk("m0 frame period", int'(frame_start), 1);

        go(60);
        a0 = acks;
        req(1);
        chk("sw busy", int'(mode_busy), 1);
        go(199);
        chk("sw busy at end", int'(mode_busy), 1);
        chk("sw mode before", int'(cur_mode), 0);
        chk("sw no early ack", acks - a0, 0);
        end_frame(0);
        chk("sw ack", int'(mode_ack), 1);
        chk("sw frame_start", int'(frame_start), 1);
        chk("sw cur_mode", int'(cur_mode), 1);
        chk("sw busy clr", int'(mode_busy), 0);
        chk("sw new syncs", int'({de, hsync, vsync}), 3'b100);
        tick();
        chk("sw ack pulse", int'(mode_ack), 0);
        run_vecs(1);
        end_frame(1);
        chk("m1 frame period", int'(frame_start), 1);
        chk("m1 no ack idle", int'(mode_ack), 0);

        go(30);
        a0 = acks;
        req(2);
        go(60);
        req(0);
        end_frame(1);
        go(5);
        chk("dbl one ack", acks - a0, 1);
        chk("dbl cur_mode", int'(cur_mode), 0);

        go(10);
        req(1);
        go(199);
        mode_sel = 2'd2;
        mode_req = 1'b1;
        end_frame(0);
        mode_req = 1'b0;
        chk("edge cur_mode", int'(cur_mode), 1);
        chk("edge ack", int'(mode_ack), 1);
        chk("edge busy kept", int'(mode_busy), 1);
        end_frame(1);
        chk("edge2 cur_mode", int'(cur_mode), 2);
        chk("edge2 ack", int'(mode_ack), 1);
        chk("edge2 busy", int'(mode_busy), 0);
        chk("edge2 frame_start", int'(frame_start), 1);
        run_vecs(2);

        end_frame(2);
        go(16);
        a0 = acks;
        req(3);
        chk("inv err", int'(mode_err), 1);
        chk("inv busy", int'(mode_busy), 0);
        tick();
        chk("inv err pulse", int'(mode_err), 0);
        end_frame(2);
        chk("inv no ack", acks - a0, 0);
        chk("inv cur_mode", int'(cur_mode), 2);
        go(5);
        req(0);
        req(3);
        chk("inv2 err", int'(mode_err), 1);
        chk("inv2 busy", int'(mode_busy), 1);
        end_frame(2);
        chk("inv2 cur_mode", int'(cur_mode), 0);
        chk("inv2 ack", int'(mode_ack), 1);

        go(20);
        req(1);
        chk("rstreq busy", int'(mode_busy), 1);
        rst_n = 1'b0;
        #1;
        chk("rstreq busy clr", int'(mode_busy), 0);
        chk("rstreq cur_mode", int'(cur_mode), 0);
        chk("rstreq ready", int'(ready), 0);
        chk("rstreq hv", int'(h_cnt) + int'(v_cnt), 0);
        chk("rstreq hsync", int'(hsync), 1);
        tick(); tick();
        rst_n = 1'b1;
        a0 = acks;
        powerup();
        end_frame(0);
        tick();
        chk("rstreq no ack", acks - a0, 0);
        chk("rstreq mode kept", int'(cur_mode), 0);
        chk("rstreq busy idle", int'(mode_busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
